// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - state encoding and CPOL/CPHA mode decode for spi_master_frame
package spi_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEAD = 3'd1;
    localparam logic [2:0] ST_HALF = 3'd2;
    localparam logic [2:0] ST_EDGE = 3'd3;
    localparam logic [2:0] ST_TAIL = 3'd4;
    localparam logic [2:0] ST_NEXT = 3'd5;
    localparam logic [2:0] ST_GAP  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LEAD = ST_LEAD,
        S_HALF = ST_HALF,
        S_EDGE = ST_EDGE,
        S_TAIL = ST_TAIL,
        S_NEXT = ST_NEXT,
        S_GAP  = ST_GAP
    } state_t;

    typedef struct packed {
        logic idle_lvl;
        logic sample_odd;
    } spi_mode_t;

    // Leading (odd-numbered) edges sample when CPHA=0, trailing ones when CPHA=1.
    function automatic spi_mode_t spi_mode_decode(input logic cpol, input logic cpha);
        spi_mode_t m;
        m.idle_lvl   = cpol;
        m.sample_odd = ~cpha;
        return m;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - half-period counter, sclk toggle and edge counter for spi_master_frame
module spi_clk_gen #(
    parameter int DIV_W  = 16,
    parameter int ECNT_W = 5
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DIV_W-1:0]  div_i,
    input  logic              restart_i,
    input  logic              edge_i,
    input  logic              edge_clr_i,
    input  logic              sclk_load_i,
    input  logic              sclk_val_i,
    output logic              half_end_o,
    output logic              pre_end_o,
    output logic [ECNT_W-1:0] edge_cnt_o,
    output logic              sclk_o
);

    logic [DIV_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [ECNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic              sclk_q, sclk_d;

    assign cnt_inc    = cnt_q + 1'b1;
    assign half_end_o = (cnt_q == div_i);
    // The edge cycle closes a half-period, so the waiting state leaves one cycle early.
    assign pre_end_o  = (cnt_inc == div_i);
    assign edge_cnt_o = edge_cnt_q;
    assign sclk_o     = sclk_q;

    always_comb begin
        cnt_d      = restart_i ? '0 : (half_end_o ? cnt_q : cnt_inc);
        edge_cnt_d = edge_cnt_q;
        if (edge_clr_i)
            edge_cnt_d = '0;
        else if (edge_i)
            edge_cnt_d = edge_cnt_q + 1'b1;
        sclk_d = sclk_q;
        if (sclk_load_i)
            sclk_d = sclk_val_i;
        else if (edge_i)
            sclk_d = ~sclk_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q      <= '0;
            edge_cnt_q <= '0;
            sclk_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sclk_q     <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_frame.sv
// rtl/spi_master_frame.sv - multi-word SPI master with runtime mode and chip-select frames
// Optional SPI_MASTER_LSB_FIRST_EN adds cfg_lsb_first for LSB-first transfers.
module spi_master_frame
    import spi_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int CS_NUM = 4,
    parameter  int DIV_W  = 16,
    localparam int SEL_W  = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic              cfg_lsb_first,
`endif
    input  logic [DIV_W-1:0]  clk_div_val,
    input  logic [SEL_W-1:0]  cs_sel,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic [CS_NUM-1:0] cs_n,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    localparam int ECNT_W = $clog2(2 * DATA_W) + 1;
    localparam logic [ECNT_W-1:0] LAST_EDGE = ECNT_W'(2 * DATA_W);

    state_t            state_q, state_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, last_q, last_d, lsb_q, lsb_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [CS_NUM-1:0] cs_n_q, cs_n_d;
    logic              mosi_q, mosi_d, rx_valid_q, rx_valid_d;
    logic              accept, half_end, pre_end, restart, edge_p, edge_clr, sclk_load, sclk_val;
    logic              lsb_in, load_lsb, edge_odd, last_edge;
    logic [ECNT_W-1:0] edge_cnt, edge_nxt;
    logic [DATA_W-1:0] word_ord;
    state_t            next_half;
    spi_mode_t         mode;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign lsb_in = cfg_lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    assign tx_ready  = (state_q == S_IDLE) | (state_q == S_NEXT);
    assign accept    = tx_valid & tx_ready;
    assign busy      = (state_q != S_IDLE);
    assign cs_n      = cs_n_q;
    assign mosi      = mosi_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign mode      = spi_mode_decode(cpol_q, cpha_q);
    assign edge_nxt  = edge_cnt + 1'b1;
    assign edge_odd  = ~edge_cnt[0];
    assign last_edge = (edge_nxt == LAST_EDGE);
    // A zero divider has no waiting cycles, so edges follow each other directly.
    assign next_half = (div_q == '0) ? S_EDGE : S_HALF;
    assign restart   = (state_d != state_q) | (state_q == S_EDGE);

    // The transmit shifter always emits from its MSB; LSB-first words are loaded reversed.
    always_comb begin
        load_lsb = (state_q == S_IDLE) ? lsb_in : lsb_q;
        word_ord = tx_data;
        if (load_lsb)
            for (int i = 0; i < DATA_W; i++)
                word_ord[i] = tx_data[DATA_W-1-i];
    end

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        last_d     = last_q;
        lsb_d      = lsb_q;
        div_d      = div_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        edge_p     = 1'b0;
        edge_clr   = 1'b0;
        sclk_load  = 1'b0;
        sclk_val   = mode.idle_lvl;
        case (state_q)
            S_IDLE: begin
                sclk_load = 1'b1;
                sclk_val  = cfg_cpol;
                if (accept) begin
                    cpol_d   = cfg_cpol;
                    cpha_d   = cfg_cpha;
                    lsb_d    = lsb_in;
                    div_d    = clk_div_val;
                    last_d   = tx_last;
                    edge_clr = 1'b1;
                    for (int i = 0; i < CS_NUM; i++)
                        cs_n_d[i] = (cs_sel != SEL_W'(i));
                    if (!cfg_cpha) begin
                        mosi_d  = word_ord[DATA_W-1];
                        tx_sh_d = word_ord << 1;
                    end else begin
                        tx_sh_d = word_ord;
                    end
                    state_d = S_LEAD;
                end
            end
            S_LEAD: if (half_end) state_d = next_half;
            S_HALF: if (pre_end) state_d = S_EDGE;
            S_EDGE: begin
                edge_p = 1'b1;
                if (edge_odd == mode.sample_odd) begin
                    rx_sh_d = lsb_q ? {miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], miso};
                end else if (!last_edge) begin
                    mosi_d  = tx_sh_q[DATA_W-1];
                    tx_sh_d = tx_sh_q << 1;
                end
                state_d = last_edge ? S_TAIL : next_half;
            end
            S_TAIL: begin
                if (half_end) begin
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                    if (last_q) begin
                        cs_n_d  = '1;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (accept) begin
                    last_d   = tx_last;
                    edge_clr = 1'b1;
                    if (!cpha_q) begin
                        mosi_d  = word_ord[DATA_W-1];
                        tx_sh_d = word_ord << 1;
                    end else begin
                        tx_sh_d = word_ord;
                    end
                    state_d = next_half;
                end
            end
            S_GAP:   if (half_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            last_q     <= 1'b0;
            lsb_q      <= 1'b0;
            div_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            cs_n_q     <= '1;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            last_q     <= last_d;
            lsb_q      <= lsb_d;
            div_q      <= div_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    spi_clk_gen #(
        .DIV_W  (DIV_W),
        .ECNT_W (ECNT_W)
    ) u_clk_gen (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .div_i       (div_q),
        .restart_i   (restart),
        .edge_i      (edge_p),
        .edge_clr_i  (edge_clr),
        .sclk_load_i (sclk_load),
        .sclk_val_i  (sclk_val),
        .half_end_o  (half_end),
        .pre_end_o   (pre_end),
        .edge_cnt_o  (edge_cnt),
        .sclk_o      (sclk)
    );

endmodule
